// File: rtl/spi_ram_arbiter.sv
// Two-port arbiter for the single-port command RAM. An address command locks
// the RAM to one requester until the matching data command closes the pair,
// so the RAM's shared address registers never see interleaved traffic.
// Read data returns only to the requester that issued the read.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no lock; arbitrate valid ports (rr_ptr breaks ties)
// ST_OWN     | locked to r_owner after WR_ADDR/RD_ADDR; idle timer running
// ST_WAIT_RD | RD_DATA forwarded; waiting for ram_tx_valid or read timer
module spi_ram_arbiter #(
    parameter int LOCK_TIMEOUT = 64,
    parameter int RD_TIMEOUT   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_req0_data,
    input  logic       i_req0_valid,
    output logic       o_req0_ready,
    output logic [7:0] o_req0_rdata,
    output logic       o_req0_rvalid,
    input  logic [9:0] i_req1_data,
    input  logic       i_req1_valid,
    output logic       o_req1_ready,
    output logic [7:0] o_req1_rdata,
    output logic       o_req1_rvalid,
    output logic [9:0] o_ram_din,
    output logic       o_ram_rx_valid,
    input  logic [7:0] i_ram_dout,
    input  logic       i_ram_tx_valid,
    output logic       o_busy,
    output logic       o_owner,
    output logic       o_timeout_err
);

    localparam int IW = $clog2(LOCK_TIMEOUT + 1);
    localparam int RW = $clog2(RD_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(LOCK_TIMEOUT);
    localparam logic [RW-1:0] RD_LIMIT   = RW'(RD_TIMEOUT);

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_rr_ptr;
    logic            r_owner;
    logic [IW-1:0]   r_idle_cnt;
    logic [RW-1:0]   r_rd_cnt;
    logic [9:0]      r_ram_din;
    logic            r_ram_rx_valid;
    logic [7:0]      r_rdata0;
    logic [7:0]      r_rdata1;
    logic            r_rvalid0;
    logic            r_rvalid1;
    logic            r_timeout_err;

    logic            w_grant;
    logic            w_ready0;
    logic            w_ready1;
    logic            w_accept;
    logic            w_port;
    logic [9:0]      w_cmd;
    logic [1:0]      w_op;
    logic [IW-1:0]   w_idle_next;
    logic [RW-1:0]   w_rd_next;

    // Grant selection and per-state ready: open arbitration in IDLE, owner only in OWN, nobody in WAIT_RD
    always_comb begin
        w_grant  = r_rr_ptr;
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        if (i_req0_valid && !i_req1_valid) begin
            w_grant = 1'b0;
        end else if (!i_req0_valid && i_req1_valid) begin
            w_grant = 1'b1;
        end
        case (r_state)
            ST_IDLE: begin
                w_ready0 = i_req0_valid && !w_grant;
                w_ready1 = i_req1_valid && w_grant;
            end
            ST_OWN: begin
                w_ready0 = i_req0_valid && !r_owner;
                w_ready1 = i_req1_valid && r_owner;
            end
            default: begin
                w_ready0 = 1'b0;
                w_ready1 = 1'b0;
            end
        endcase
    end

    assign w_accept    = w_ready0 | w_ready1;
    assign w_port      = w_ready1;
    assign w_cmd       = w_ready1 ? i_req1_data : i_req0_data;
    assign w_op        = w_cmd[9:8];
    assign w_idle_next = r_idle_cnt + IW'(1);
    assign w_rd_next   = r_rd_cnt + RW'(1);

    // Lock FSM, command forwarding, timers and read-data return
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_rr_ptr       <= 1'b0;
            r_owner        <= 1'b0;
            r_idle_cnt     <= '0;
            r_rd_cnt       <= '0;
            r_ram_din      <= '0;
            r_ram_rx_valid <= 1'b0;
            r_rdata0       <= '0;
            r_rdata1       <= '0;
            r_rvalid0      <= 1'b0;
            r_rvalid1      <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_ram_rx_valid <= w_accept;
            r_rvalid0      <= 1'b0;
            r_rvalid1      <= 1'b0;
            r_timeout_err  <= 1'b0;
            if (w_accept) begin
                r_ram_din <= w_cmd;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_port;
                        case (w_op)
                            OP_WR_ADDR, OP_RD_ADDR: begin
                                r_state    <= ST_OWN;
                                r_idle_cnt <= '0;
                            end
                            OP_RD_DATA: begin
                                r_state  <= ST_WAIT_RD;
                                r_rd_cnt <= '0;
                            end
                            default: begin
                                // orphan write: forwarded, lock not taken, fairness passes on
                                r_rr_ptr <= !w_port;
                            end
                        endcase
                    end
                end
                ST_OWN: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_WR_ADDR, OP_RD_ADDR: begin
                                r_idle_cnt <= '0;
                            end
                            OP_WR_DATA: begin
                                r_state  <= ST_IDLE;
                                r_rr_ptr <= !r_owner;
                            end
                            default: begin
                                r_state  <= ST_WAIT_RD;
                                r_rd_cnt <= '0;
                            end
                        endcase
                    end else if (w_idle_next == IDLE_LIMIT) begin
                        r_state       <= ST_IDLE;
                        r_timeout_err <= 1'b1;
                        r_rr_ptr      <= !r_owner;
                        r_idle_cnt    <= '0;
                    end else begin
                        r_idle_cnt <= w_idle_next;
                    end
                end
                ST_WAIT_RD: begin
                    if (i_ram_tx_valid) begin
                        if (r_owner) begin
                            r_rdata1  <= i_ram_dout;
                            r_rvalid1 <= 1'b1;
                        end else begin
                            r_rdata0  <= i_ram_dout;
                            r_rvalid0 <= 1'b1;
                        end
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= !r_owner;
                        r_rd_cnt <= '0;
                    end else if (w_rd_next == RD_LIMIT) begin
                        r_state       <= ST_IDLE;
                        r_timeout_err <= 1'b1;
                        r_rr_ptr      <= !r_owner;
                        r_rd_cnt      <= '0;
                    end else begin
                        r_rd_cnt <= w_rd_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req0_ready   = w_ready0;
    assign o_req1_ready   = w_ready1;
    assign o_req0_rdata   = r_rdata0;
    assign o_req1_rdata   = r_rdata1;
    assign o_req0_rvalid  = r_rvalid0;
    assign o_req1_rvalid  = r_rvalid1;
    assign o_ram_din      = r_ram_din;
    assign o_ram_rx_valid = r_ram_rx_valid;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_owner        = r_owner;
    assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: a vector table for arbitration/locking, then
// hand-written sequences for lock timeout, read timeout and mid-read reset.
// Forwarded commands and read returns are checked against scoreboard queues.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] req0_data, req1_data;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_rdata, req1_rdata;
    logic       req0_rvalid, req1_rvalid;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;
    logic       busy, owner, timeout_err;

    spi_ram_arbiter #(.LOCK_TIMEOUT(64), .RD_TIMEOUT(8)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req0_data    (req0_data),
        .i_req0_valid   (req0_valid),
        .o_req0_ready   (req0_ready),
        .o_req0_rdata   (req0_rdata),
        .o_req0_rvalid  (req0_rvalid),
        .i_req1_data    (req1_data),
        .i_req1_valid   (req1_valid),
        .o_req1_ready   (req1_ready),
        .o_req1_rdata   (req1_rdata),
        .o_req1_rvalid  (req1_rvalid),
        .o_ram_din      (ram_din),
        .o_ram_rx_valid (ram_rx_valid),
        .i_ram_dout     (ram_dout),
        .i_ram_tx_valid (ram_tx_valid),
        .o_busy         (busy),
        .o_owner        (owner),
        .o_timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;

    typedef struct {
        bit         port;
        logic [7:0] data;
    } rd_t;

    logic [9:0] ram_q[$];
    rd_t        rd_q[$];

    typedef struct {
        bit         v0;
        logic [9:0] d0;
        bit         v1;
        logic [9:0] d1;
        bit         tx;
        logic [7:0] dout;
        bit         r0;
        bit         r1;
        bit         rd;
        bit         busy;
        bit         own;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int v0, input int d0, input int v1, input int d1,
                                input int tx, input int dout, input int r0, input int r1,
                                input int rd, input int bsy, input int own);
        vec_t v;
        v.v0 = v0[0];   v.d0 = 10'(d0);
        v.v1 = v1[0];   v.d1 = 10'(d1);
        v.tx = tx[0];   v.dout = 8'(dout);
        v.r0 = r0[0];   v.r1 = r1[0];
        v.rd = rd[0];   v.busy = bsy[0];
        v.own = own[0];
        return v;
    endfunction

    // Scoreboard monitor, sampling between clock edges
    always @(negedge clk) begin
        if (ram_rx_valid) begin
            if (ram_q.size() == 0) check("ram_unexpected_cmd", ram_rx_valid, 0);
            else check("ram_din", ram_din, ram_q.pop_front());
        end
        if (req0_rvalid || req1_rvalid) begin
            if (rd_q.size() == 0) begin
                check("rvalid_unexpected", {req1_rvalid, req0_rvalid}, 0);
            end else begin
                rd_t e;
                e = rd_q.pop_front();
                check("rvalid_port", {req1_rvalid, req0_rvalid}, e.port ? 2 : 1);
                check("rdata", e.port ? req1_rdata : req0_rdata, e.data);
            end
        end
        if (timeout_err) err_seen++;
    end

    function automatic logic [63:0] all_outputs();
        return {req0_ready, req0_rdata, req0_rvalid, req1_ready, req1_rdata, req1_rvalid,
                ram_din, ram_rx_valid, busy, owner, timeout_err};
    endfunction

    initial begin
        int found;
        int leak;
        vec_t v;

        vecs[0]  = mk(1, 'h012, 1, 'h044, 0, 0,    1, 0, 0, 1, 0);
        vecs[1]  = mk(1, 'h1AB, 1, 'h044, 0, 0,    1, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0,     1, 'h044, 0, 0,    0, 1, 0, 1, 1);
        vecs[3]  = mk(0, 0,     1, 'h1CD, 0, 0,    0, 1, 0, 0, 1);
        vecs[4]  = mk(0, 0,     1, 'h205, 0, 0,    0, 1, 0, 1, 1);
        vecs[5]  = mk(0, 0,     1, 'h300, 0, 0,    0, 1, 0, 1, 1);
        vecs[6]  = mk(1, 'h077, 0, 0,     0, 0,    0, 0, 0, 1, 1);
        vecs[7]  = mk(1, 'h077, 0, 0,     1, 'h5A, 0, 0, 1, 0, 1);
        vecs[8]  = mk(1, 'h077, 0, 0,     0, 0,    1, 0, 0, 1, 0);
        vecs[9]  = mk(1, 'h1FF, 0, 0,     0, 0,    1, 0, 0, 0, 0);
        vecs[10] = mk(0, 0,     1, 'h111, 0, 0,    0, 1, 0, 0, 1);
        vecs[11] = mk(1, 'h100, 1, 'h101, 0, 0,    1, 0, 0, 0, 0);
        vecs[12] = mk(1, 'h102, 1, 'h103, 0, 0,    0, 1, 0, 0, 1);

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_data = '0;
        req1_valid = 1'b0; req1_data = '0;
        ram_tx_valid = 1'b0; ram_dout = '0;
        #3;
        check("reset_outputs", all_outputs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: tie after reset, lock hold-off, back-to-back, read return, orphans, rr toggling
        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            req0_valid = v.v0; req0_data = v.d0;
            req1_valid = v.v1; req1_data = v.d1;
            ram_tx_valid = v.tx; ram_dout = v.dout;
            #1;
            check($sformatf("v%0d_ready0", i), req0_ready, v.r0);
            check($sformatf("v%0d_ready1", i), req1_ready, v.r1);
            if (v.r0) ram_q.push_back(v.d0);
            if (v.r1) ram_q.push_back(v.d1);
            if (v.rd) rd_q.push_back('{v.own, v.dout});
            @(posedge clk); #1;
            check($sformatf("v%0d_busy", i), busy, v.busy);
            check($sformatf("v%0d_owner", i), owner, v.own);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; ram_tx_valid = 1'b0;
        @(posedge clk); #1;

        // Lock timeout with port 1 waiting
        req0_valid = 1'b1; req0_data = 10'h021;
        #1;
        check("lock_open_ready0", req0_ready, 1);
        ram_q.push_back(10'h021);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 10'h031;
        found = 0; leak = 0;
        for (int c = 1; c <= 80 && found == 0; c++) begin
            @(posedge clk); #1;
            if (timeout_err) found = c;
            else if (req1_ready) leak++;
        end
        check("lock_timeout_cycle", found, 64);
        check("lock_ready1_leak", leak, 0);
        check("lock_timeout_busy", busy, 0);
        check("lock_waiter_ready1", req1_ready, 1);
        ram_q.push_back(10'h031);
        @(posedge clk); #1;
        check("lock_waiter_owner", owner, 1);
        check("lock_err_one_cycle", timeout_err, 0);
        req1_data = 10'h131;
        ram_q.push_back(10'h131);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        check("lock_waiter_closed", busy, 0);

        // Read timeout, then a stray tx_valid
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data = 10'h3C0;
        #1;
        check("rdto_ready0", req0_ready, 1);
        ram_q.push_back(10'h3C0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        found = 0;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            @(posedge clk); #1;
            if (timeout_err) found = c;
        end
        check("rd_timeout_cycle", found, 8);
        check("rd_timeout_busy", busy, 0);
        ram_tx_valid = 1'b1; ram_dout = 8'hEE;
        @(posedge clk); #1;
        ram_tx_valid = 1'b0;
        @(posedge clk); #1;
        check("stray_rdata0", req0_rdata, 8'h00);
        check("stray_rdata1_held", req1_rdata, 8'h5A);
        check("stray_busy", busy, 0);
        check("stray_no_err", timeout_err, 0);
        check("timeout_pulse_count", err_seen, 2);

        // Reset during WAIT_RD, with a forwarded command still on the RAM strobe
        req1_valid = 1'b1; req1_data = 10'h3AA;
        #1;
        check("rst_seq_ready1", req1_ready, 1);
        ram_q.push_back(10'h3AA);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        check("rst_seq_owner", owner, 1);
        check("rst_seq_rx_valid", ram_rx_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_async_outputs", all_outputs(), 0);
        ram_q.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data = 10'h0AA;
        req1_valid = 1'b1; req1_data = 10'h0BB;
        #1;
        check("post_reset_tie_ready0", req0_ready, 1);
        check("post_reset_tie_ready1", req1_ready, 0);
        ram_q.push_back(10'h0AA);
        @(posedge clk); #1;
        req0_data = 10'h1AA;
        ram_q.push_back(10'h1AA);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("post_reset_closed", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("ram_queue_drained", ram_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Shares the single-port command RAM (10-bit command word in, 8-bit read data out) between two requesters: port 0 (SPI slave receive path) and port 1 (local host or test port).
- The RAM holds its write and read addresses in shared internal registers, so each address/data command pair must reach it without interleaving.
- The arbiter locks the RAM to one requester from the opening address command until the closing data command completes.
- It routes read data back only to the requester that issued the read.

Parameters:
- LOCK_TIMEOUT, 64: idle cycles allowed in OWN before the lock is force-released.
- RD_TIMEOUT, 8: cycles allowed in WAIT_RD for ram_tx_valid before abandoning the read.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_data  in  10  port 0 command word; [9:8] opcode, [7:0] payload
- req0_valid  in  1  port 0 command valid
- req0_ready  out  1  port 0 command accepted (combinational)
- req0_rdata  out  8  port 0 read data
- req0_rvalid  out  1  port 0 read data valid, 1-cycle pulse
- req1_data / req1_valid / req1_ready / req1_rdata / req1_rvalid: same as port 0, for port 1
- ram_din  out  10  command word to RAM
- ram_rx_valid  out  1  command strobe to RAM
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read data valid
- busy  out  1  high in any state other than IDLE
- owner  out  1  current/last granted port
- timeout_err  out  1  1-cycle pulse on either timeout

Behaviour:
- Opcodes:
  - 00 WR_ADDR opens a write; 01 WR_DATA closes it.
  - 10 RD_ADDR opens a read; 11 RD_DATA closes it and requests data.
- Reset values: all outputs 0, state IDLE, rr_ptr=0 (port 0 favoured), counters 0.
- Acceptance: a command is accepted when reqN_valid && reqN_ready in the same cycle.
- Forwarding: ram_din and ram_rx_valid are registered and appear the cycle after acceptance. ram_rx_valid is high for exactly 1 cycle per accepted command.
- State IDLE:
  - ready is high for the winning valid port only.
  - If one port is valid, it wins. If both are valid, the port selected by rr_ptr wins.
  - On acceptance: owner is set to the winning port.
  - Opcode 00 or 10 goes to OWN.
  - Opcode 11 (orphan read) goes to WAIT_RD.
  - Opcode 01 (orphan write) is forwarded, stays in IDLE, and rr_ptr toggles to the other port.
- State OWN:
  - Only the owner's ready equals its valid; the other port's ready is 0.
  - Owner sends 00 or 10: forwarded, stay in OWN, idle counter cleared.
  - Owner sends 01: forwarded, go to IDLE, rr_ptr becomes the other port.
  - Owner sends 11: forwarded, go to WAIT_RD.
  - The idle counter increments each cycle the owner is not accepted. When it reaches LOCK_TIMEOUT, go to IDLE, pulse timeout_err, and set rr_ptr to the other port.
- State WAIT_RD:
  - Both ready are 0.
  - The RD counter starts at 0 on entry.
  - On ram_tx_valid: capture ram_dout into the owner's rdata and pulse the owner's rvalid in the next cycle. Go to IDLE with rr_ptr set to the other port.
  - If the counter reaches RD_TIMEOUT first: go to IDLE, pulse timeout_err, and assert no rvalid.
- reqN_rdata holds its last captured value. The non-owner's rdata and rvalid never change.
- A ram_tx_valid outside WAIT_RD is ignored, with no rvalid and no error.
- Throughput: back-to-back acceptance is allowed, one command per cycle in IDLE or OWN.
- Simultaneous events in the closing cycle: a non-owner valid is not granted in that cycle. It is arbitrated in the next IDLE cycle.
- Reset asserted mid-transaction: everything returns to reset values immediately. Any in-flight ram_rx_valid is dropped.
- Counter widths: $clog2(param+1).

Test Plan:
- Port 0 sends 00 0x12, then 01 0xAB -> ram_din = 0x012 then 0x1AB, one ram_rx_valid each, busy falls after 01, rr_ptr=1.
- Both ports assert 00 in IDLE after reset -> port 0 granted; port 1 ready=0 until port 0 sends 01; port 1 then granted next cycle.
- Port 1 sends 10 0x05 then 11; RAM returns tx_valid with 0x5A two cycles later -> req1_rdata=0x5A with a 1-cycle req1_rvalid; req0_rvalid stays 0.
- Port 0 sends 00 and then goes silent -> after 64 cycles timeout_err pulses once and state is IDLE; a pending port 1 00 is granted the next cycle.
- Port 0 sends 11 and RAM never responds -> after 8 cycles timeout_err pulses, no rvalid; a stray tx_valid afterwards is ignored.
- rst_n dropped during WAIT_RD -> all outputs 0 asynchronously; after release, port 0 is favoured in a tie.
